// File: rtl/arith_bitwise_pipe_if.sv
// Operand/result stream bundle for the pipelined bitwise unit.
// master drives operands and result_ready; slave is the functional unit.
interface arith_bitwise_pipe_if #(
  parameter int unsigned WIDTH = 32
);
  logic             a_valid;
  logic             a_ready;
  logic [WIDTH-1:0] a_data;
  logic             b_valid;
  logic             b_ready;
  logic [WIDTH-1:0] b_data;
  logic [2:0]       op;
  logic             result_valid;
  logic             result_ready;
  logic [WIDTH-1:0] result_data;
  logic             result_zero;

  modport master (
    output a_valid, a_data, b_valid, b_data, op, result_ready,
    input  a_ready, b_ready, result_valid, result_data, result_zero
  );

  modport slave (
    input  a_valid, a_data, b_valid, b_data, op, result_ready,
    output a_ready, b_ready, result_valid, result_data, result_zero
  );
endinterface

// File: rtl/arith_bitwise_pipe.sv
// Joins two operand streams, applies one of eight bitwise ops and carries the
// result through LATENCY compacting register stages under valid/ready flow control.
module arith_bitwise_pipe #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned LATENCY = 2
) (
  input  logic                clk,
  input  logic                rst,
  arith_bitwise_pipe_if.slave bus,
  output logic                busy
);

  logic [LATENCY-1:0] v_q;
  logic [LATENCY-1:0] zero_q;
  logic [WIDTH-1:0]   data_q [LATENCY];
  logic [LATENCY-1:0] can_load;
  logic               in_ready;
  logic               accept;
  logic [WIDTH-1:0]   op_result;

  always_comb begin
    op_result = '0;
    case (bus.op)
      3'd0: op_result = bus.a_data & bus.b_data;
      3'd1: op_result = bus.a_data | bus.b_data;
      3'd2: op_result = bus.a_data ^ bus.b_data;
      3'd3: op_result = ~(bus.a_data & bus.b_data);
      3'd4: op_result = ~(bus.a_data | bus.b_data);
      3'd5: op_result = ~(bus.a_data ^ bus.b_data);
      3'd6: op_result = bus.a_data & ~bus.b_data;
      3'd7: op_result = bus.a_data | ~bus.b_data;
    endcase
  end

  // A stage may load when any stage from it to the output is empty, or the output drains.
  always_comb begin
    logic all_full;
    can_load = '0;
    for (int i = 0; i < int'(LATENCY); i++) begin
      all_full = 1'b1;
      for (int j = i; j < int'(LATENCY); j++) begin
        all_full = all_full & v_q[j];
      end
      can_load[i] = ~all_full | bus.result_ready;
    end
  end

  assign in_ready    = can_load[0];
  assign accept      = bus.a_valid & bus.b_valid & in_ready;
  assign bus.a_ready = in_ready & bus.b_valid;
  assign bus.b_ready = in_ready & bus.a_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_q    <= '0;
      zero_q <= '1;
      for (int i = 0; i < int'(LATENCY); i++) begin
        data_q[i] <= '0;
      end
    end else begin
      if (can_load[0]) begin
        v_q[0] <= accept;
        if (accept) begin
          data_q[0] <= op_result;
          zero_q[0] <= (op_result == '0);
        end
      end
      // Payload only moves with a valid bit so idle stages never pick up garbage.
      for (int i = 1; i < int'(LATENCY); i++) begin
        if (can_load[i]) begin
          v_q[i] <= v_q[i-1];
          if (v_q[i-1]) begin
            data_q[i] <= data_q[i-1];
            zero_q[i] <= zero_q[i-1];
          end
        end
      end
    end
  end

  assign bus.result_valid = v_q[LATENCY-1];
  assign bus.result_data  = data_q[LATENCY-1];
  assign bus.result_zero  = zero_q[LATENCY-1];
  assign busy             = |v_q;

endmodule

// File: tb/tb_arith_bitwise_pipe.sv
// Bench for arith_bitwise_pipe: directed checks on a 32-bit/2-stage instance and
// randomized scoreboard stress on an 8-bit/3-stage instance.
module tb_arith_bitwise_pipe;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic busy0;
  logic busy1;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  arith_bitwise_pipe_if #(.WIDTH(32)) bus0 ();
  arith_bitwise_pipe_if #(.WIDTH(8))  bus1 ();

  arith_bitwise_pipe #(.WIDTH(32), .LATENCY(2)) u0 (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus0),
    .busy (busy0)
  );

  arith_bitwise_pipe #(.WIDTH(8), .LATENCY(3)) u1 (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus1),
    .busy (busy1)
  );

  typedef struct {
    logic [7:0] data;
    int         cyc;
  } ent_t;

  logic [31:0] q0[$];
  ent_t        q1[$];

  logic        acc0, rf0, rv0, rz0, ar0, br0, bz0;
  logic [31:0] rd0;

  function automatic logic [31:0] ref_op(input logic [2:0] o, input logic [31:0] a,
                                         input logic [31:0] b);
    case (o)
      3'd0: return a & b;
      3'd1: return a | b;
      3'd2: return a ^ b;
      3'd3: return ~(a & b);
      3'd4: return ~(a | b);
      3'd5: return ~(a ^ b);
      3'd6: return a & ~b;
      default: return a | ~b;
    endcase
  endfunction

  // One cycle on u0: inputs already applied at the negedge, observe, step to next negedge.
  task automatic cycle0();
    #1;
    ar0  = bus0.a_ready;
    br0  = bus0.b_ready;
    acc0 = bus0.a_valid & bus0.b_valid & bus0.a_ready;
    rv0  = bus0.result_valid;
    rf0  = bus0.result_valid & bus0.result_ready;
    rd0  = bus0.result_data;
    rz0  = bus0.result_zero;
    bz0  = busy0;
    if (acc0) q0.push_back(ref_op(bus0.op, bus0.a_data, bus0.b_data));
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle0();
    bus0.a_valid = 1'b0;
    bus0.b_valid = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    #1;
    total++; if (bus0.result_valid !== 1'b0)
      $display("FAIL reset_valid: got %b expected 0", bus0.result_valid);
    total++; if (busy0 !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy0);
    total++; if (bus0.result_data !== 32'h0)
      $display("FAIL reset_data: got %h expected 0", bus0.result_data);
    total++; if (bus0.result_zero !== 1'b1)
      $display("FAIL reset_zero: got %b expected 1", bus0.result_zero);
    total++; if (bus1.result_valid !== 1'b0 || busy1 !== 1'b0)
      $display("FAIL reset_u1: got valid=%b busy=%b expected 0 0", bus1.result_valid, busy1);
    bad += (bus0.result_valid !== 1'b0) + (busy0 !== 1'b0) + (bus0.result_data !== 32'h0)
         + (bus0.result_zero !== 1'b1) + (bus1.result_valid !== 1'b0 || busy1 !== 1'b0);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_op_sweep();
    logic [31:0] exp_t [8];
    int nres = 0;
    exp_t = '{32'hF000_F000, 32'hFFF0_FFF0, 32'h0FF0_0FF0, 32'h0FFF_0FFF,
              32'h000F_000F, 32'hF00F_F00F, 32'h00F0_00F0, 32'hF0FF_F0FF};
    bus0.result_ready = 1'b1;
    for (int c = 0; c < 12; c++) begin
      bus0.a_valid = (c < 8);
      bus0.b_valid = (c < 8);
      bus0.a_data  = 32'hF0F0_F0F0;
      bus0.b_data  = 32'hFF00_FF00;
      bus0.op      = 3'(c);
      cycle0();
      if (c < 8) begin
        total++;
        if (acc0 !== 1'b1) begin bad++; $display("FAIL sweep_accept[%0d]: got %b expected 1", c, acc0); end
      end
      if (rf0 === 1'b1) begin
        void'(q0.pop_front());
        total++;
        if (nres >= 8 || rd0 !== exp_t[nres] || c != nres + 2) begin
          bad++;
          $display("FAIL sweep_result[%0d]: got %h at cycle %0d expected %h at cycle %0d",
                   nres, rd0, c, (nres < 8) ? exp_t[nres] : 32'h0, nres + 2);
        end
        nres++;
      end
    end
    total++;
    if (nres != 8) begin bad++; $display("FAIL sweep_count: got %0d expected 8", nres); end
  endtask

  task automatic test_join();
    int nres = 0;
    logic [31:0] e;
    bus0.result_ready = 1'b1;
    bus0.a_valid = 1'b1;
    bus0.b_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      bus0.a_data = $urandom;
      bus0.op     = 3'($urandom_range(0, 7));
      cycle0();
      total++;
      if (ar0 !== 1'b0 || br0 !== 1'b1 || acc0 !== 1'b0) begin
        bad++;
        $display("FAIL join_wait[%0d]: got a_ready=%b b_ready=%b acc=%b expected 0 1 0",
                 c, ar0, br0, acc0);
      end
    end
    bus0.b_valid = 1'b1;
    bus0.b_data  = $urandom;
    cycle0();
    total++;
    if (acc0 !== 1'b1) begin bad++; $display("FAIL join_accept: got %b expected 1", acc0); end
    idle0();
    for (int c = 0; c < 6; c++) begin
      cycle0();
      if (rf0 === 1'b1) begin
        e = (q0.size() > 0) ? q0.pop_front() : 32'hx;
        nres++;
        total++;
        if (rd0 !== e) begin bad++; $display("FAIL join_data: got %h expected %h", rd0, e); end
      end
    end
    total++;
    if (nres != 1) begin bad++; $display("FAIL join_count: got %0d expected 1", nres); end
  endtask

  task automatic test_backpressure();
    int nacc = 0;
    int ndrain = 0;
    logic [31:0] held_d, e;
    logic held_z;
    bus0.result_ready = 1'b0;
    bus0.a_valid = 1'b1;
    bus0.b_valid = 1'b1;
    for (int c = 0; c < 6; c++) begin
      bus0.a_data = $urandom;
      bus0.b_data = $urandom;
      bus0.op     = 3'($urandom_range(0, 7));
      cycle0();
      if (acc0 === 1'b1) nacc++;
      if (c >= 2) begin
        total++;
        if (ar0 !== 1'b0 || br0 !== 1'b0 || rv0 !== 1'b1 || bz0 !== 1'b1) begin
          bad++;
          $display("FAIL bp_full[%0d]: got a_ready=%b b_ready=%b valid=%b busy=%b expected 0 0 1 1",
                   c, ar0, br0, rv0, bz0);
        end
      end
      if (c == 2) begin
        held_d = rd0;
        held_z = rz0;
      end else if (c > 2) begin
        total++;
        if (rd0 !== held_d || rz0 !== held_z) begin
          bad++;
          $display("FAIL bp_stable[%0d]: got %h/%b expected %h/%b", c, rd0, rz0, held_d, held_z);
        end
      end
    end
    total++;
    if (nacc != 2) begin bad++; $display("FAIL bp_accepts: got %0d expected 2", nacc); end
    // Full pipeline, output draining: a new operand must enter in the same cycle.
    bus0.result_ready = 1'b1;
    bus0.a_data = $urandom;
    bus0.b_data = $urandom;
    cycle0();
    e = (q0.size() > 0) ? q0.pop_front() : 32'hx;
    total++;
    if (acc0 !== 1'b1 || rf0 !== 1'b1 || rd0 !== e) begin
      bad++;
      $display("FAIL bp_simul: got acc=%b drain=%b data=%h expected 1 1 %h", acc0, rf0, rd0, e);
    end
    idle0();
    for (int c = 0; c < 8; c++) begin
      cycle0();
      if (rf0 === 1'b1) begin
        e = (q0.size() > 0) ? q0.pop_front() : 32'hx;
        ndrain++;
        total++;
        if (rd0 !== e || rz0 !== (e == 32'h0)) begin
          bad++;
          $display("FAIL bp_drain: got %h/%b expected %h/%b", rd0, rz0, e, (e == 32'h0));
        end
      end
    end
    total++;
    if (ndrain != 2 || q0.size() != 0 || bz0 !== 1'b0) begin
      bad++;
      $display("FAIL bp_drain_count: got %0d left=%0d busy=%b expected 2 0 0",
               ndrain, q0.size(), bz0);
    end
  endtask

  task automatic test_zero_flag();
    logic [31:0] exp_d [2];
    logic        exp_z [2];
    int nres = 0;
    exp_d = '{32'h0, 32'h1234_5678};
    exp_z = '{1'b1, 1'b0};
    bus0.result_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      bus0.a_valid = (c < 2);
      bus0.b_valid = (c < 2);
      bus0.a_data  = 32'h1234_5678;
      bus0.b_data  = 32'h1234_5678;
      bus0.op      = (c == 0) ? 3'd2 : 3'd0;
      cycle0();
      if (rf0 === 1'b1) begin
        void'(q0.pop_front());
        total++;
        if (nres >= 2 || rd0 !== exp_d[nres] || rz0 !== exp_z[nres]) begin
          bad++;
          $display("FAIL zero_flag[%0d]: got %h/%b expected %h/%b", nres, rd0, rz0,
                   (nres < 2) ? exp_d[nres] : 32'h0, (nres < 2) ? exp_z[nres] : 1'b0);
        end
        nres++;
      end
    end
    total++;
    if (nres != 2) begin bad++; $display("FAIL zero_count: got %0d expected 2", nres); end
  endtask

  task automatic test_reset_midflight();
    logic [31:0] e;
    int nres = 0;
    bus0.result_ready = 1'b0;
    bus0.a_valid = 1'b1;
    bus0.b_valid = 1'b1;
    for (int c = 0; c < 2; c++) begin
      bus0.a_data = $urandom;
      bus0.b_data = $urandom;
      bus0.op     = 3'($urandom_range(0, 7));
      cycle0();
    end
    idle0();
    #1;
    total++;
    if (bus0.result_valid !== 1'b1 || busy0 !== 1'b1) begin
      bad++;
      $display("FAIL rst_pre: got valid=%b busy=%b expected 1 1", bus0.result_valid, busy0);
    end
    #1 rst = 1'b1;
    #1;
    total++;
    if (bus0.result_valid !== 1'b0 || busy0 !== 1'b0 || bus0.result_zero !== 1'b1
        || bus0.result_data !== 32'h0) begin
      bad++;
      $display("FAIL rst_async: got valid=%b busy=%b zero=%b data=%h expected 0 0 1 0",
               bus0.result_valid, busy0, bus0.result_zero, bus0.result_data);
    end
    rst = 1'b0;
    q0.delete();
    @(negedge clk);
    bus0.result_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      cycle0();
      total++;
      if (rv0 !== 1'b0 || bz0 !== 1'b0) begin
        bad++;
        $display("FAIL rst_stale[%0d]: got valid=%b busy=%b expected 0 0", c, rv0, bz0);
      end
    end
    bus0.a_valid = 1'b1;
    bus0.b_valid = 1'b1;
    bus0.a_data  = 32'hDEAD_BEEF;
    bus0.b_data  = 32'h0F0F_0F0F;
    bus0.op      = 3'd6;
    cycle0();
    idle0();
    for (int c = 0; c < 4; c++) begin
      cycle0();
      if (rf0 === 1'b1) begin
        e = (q0.size() > 0) ? q0.pop_front() : 32'hx;
        nres++;
        total++;
        if (rd0 !== 32'hD0A0_B0E0) begin
          bad++;
          $display("FAIL rst_resume: got %h expected d0a0b0e0", rd0);
        end
      end
    end
    total++;
    if (nres != 1) begin bad++; $display("FAIL rst_resume_count: got %0d expected 1", nres); end
  endtask

  task automatic test_random();
    localparam int L = 3;
    logic exp_ar, exp_br, exp_rv, v_before, prev_stall;
    logic [7:0] prev_data;
    logic [31:0] r;
    prev_stall = 1'b0;
    prev_data  = 8'h0;
    for (int c = 0; c < 10000 && bad < 100; c++) begin
      bus1.a_valid      = ($urandom_range(0, 3) != 0);
      bus1.b_valid      = ($urandom_range(0, 3) != 0);
      bus1.a_data       = 8'($urandom);
      bus1.b_data       = 8'($urandom);
      bus1.op           = 3'($urandom_range(0, 7));
      bus1.result_ready = ($urandom_range(0, 2) != 0);
      #1;
      v_before = bus1.result_valid;
      bus1.result_ready = ~bus1.result_ready;
      #1;
      total++;
      if (bus1.result_valid !== v_before) begin
        bad++;
        $display("FAIL rnd_valid_dep[%0d]: got %b expected %b", c, bus1.result_valid, v_before);
      end
      bus1.result_ready = ~bus1.result_ready;
      #1;
      exp_ar = bus1.b_valid & ((q1.size() < L) | bus1.result_ready);
      exp_br = bus1.a_valid & ((q1.size() < L) | bus1.result_ready);
      exp_rv = (q1.size() > 0) && (c >= q1[0].cyc + L);
      total++;
      if (bus1.a_ready !== exp_ar || bus1.b_ready !== exp_br) begin
        bad++;
        $display("FAIL rnd_ready[%0d]: got %b%b expected %b%b", c, bus1.a_ready, bus1.b_ready,
                 exp_ar, exp_br);
      end
      total++;
      if (bus1.result_valid !== exp_rv || busy1 !== (q1.size() > 0)) begin
        bad++;
        $display("FAIL rnd_valid[%0d]: got valid=%b busy=%b expected %b %b", c,
                 bus1.result_valid, busy1, exp_rv, (q1.size() > 0));
      end
      if (exp_rv) begin
        total++;
        if (bus1.result_data !== q1[0].data || bus1.result_zero !== (q1[0].data == 8'h0)) begin
          bad++;
          $display("FAIL rnd_data[%0d]: got %h/%b expected %h/%b", c, bus1.result_data,
                   bus1.result_zero, q1[0].data, (q1[0].data == 8'h0));
        end
      end
      if (prev_stall) begin
        total++;
        if (bus1.result_data !== prev_data) begin
          bad++;
          $display("FAIL rnd_hold[%0d]: got %h expected %h", c, bus1.result_data, prev_data);
        end
      end
      prev_stall = bus1.result_valid & ~bus1.result_ready;
      prev_data  = bus1.result_data;
      if (bus1.result_valid & bus1.result_ready) void'(q1.pop_front());
      if (bus1.a_valid & bus1.b_valid & bus1.a_ready) begin
        r = ref_op(bus1.op, {24'h0, bus1.a_data}, {24'h0, bus1.b_data});
        q1.push_back('{data: r[7:0], cyc: c});
      end
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  initial begin
    bus0.a_valid = 1'b0; bus0.b_valid = 1'b0; bus0.a_data = '0; bus0.b_data = '0;
    bus0.op = 3'd0; bus0.result_ready = 1'b0;
    bus1.a_valid = 1'b0; bus1.b_valid = 1'b0; bus1.a_data = '0; bus1.b_data = '0;
    bus1.op = 3'd0; bus1.result_ready = 1'b0;
    test_reset();
    test_op_sweep();
    test_join();
    test_backpressure();
    test_zero_flag();
    test_reset_midflight();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/arith_bitwise_pipe.md
Name: arith_bitwise_pipe

Overview:
- Parametrised, pipelined successor to the single-op combinational bitwise units.
- Joins two operand streams with a per-transaction opcode, computes one of eight bitwise ops, and carries the result through LATENCY registered stages under valid/ready backpressure.
- Sits in the arith library as the shared logic-op FU for mapped dataflow graphs.

Parameters:
- WIDTH, 32, operand/result bit width (>=1)
- LATENCY, 2, number of register stages between operand accept and result_valid (>=1)

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- a_valid  in  1  operand A valid
- a_ready  out  1  operand A accepted this cycle when a_valid&a_ready
- a_data  in  WIDTH  operand A
- b_valid  in  1  operand B valid
- b_ready  out  1  operand B ready
- b_data  in  WIDTH  operand B
- op  in  3  opcode, sampled only on accept
- result_valid  out  1  result valid
- result_ready  in  1  downstream ready
- result_data  out  WIDTH  result
- result_zero  out  1  result_data == 0, registered with the result
- busy  out  1  any stage holds valid data

Behaviour:
- Opcodes:
  - 0 AND a&b
  - 1 OR a|b
  - 2 XOR a^b
  - 3 NAND ~(a&b)
  - 4 NOR ~(a|b)
  - 5 XNOR ~(a^b)
  - 6 ANDN a&~b
  - 7 ORN a|~b
- All ops are full WIDTH with no carry or sign semantics.
- Join:
  - accept = a_valid & b_valid & in_ready.
  - a_ready = in_ready & b_valid; b_ready = in_ready & a_valid.
  - Neither operand is consumed alone.
  - a_ready/b_ready may depend combinationally on the other side's valid and on result_ready. No valid depends on any ready.
- Pipeline: stages s[0..LATENCY-1], each with a valid bit, a WIDTH data register and a zero-flag register.
  - Compute happens before s[0]; s[0] stores op(a,b) on accept.
- Stage advance (combinational, evaluated from the output back):
  - last stage: can_load[L-1] = ~v[L-1] | result_ready.
  - other stages: can_load[i] = ~v[i] | can_load[i+1].
  - in_ready = can_load[0].
  - Full throughput: one result per cycle when result_ready is held high.
- Latency:
  - Operand accepted at edge N appears with result_valid=1 after edge N+LATENCY-1, i.e. visible LATENCY cycles after the accepting cycle.
  - Minimum latency is 1, never combinational.
- Output:
  - result_valid = v[L-1], result_data = s[L-1].data, result_zero = s[L-1].zero.
  - While result_valid & ~result_ready, result_data and result_zero hold stable.
- Bubbles: an empty stage is filled from its upstream stage even when downstream stalls, so the pipeline compacts.
- Capacity: LATENCY entries. With result_ready=0, exactly LATENCY transactions are accepted, then a_ready=b_ready=0.
- Simultaneous events: a full pipeline with result_ready=1 and both operands valid accepts a new operand in the same cycle the last result drains.
- Ordering: strict FIFO; results leave in accept order.
- op changes while no accept occurs have no effect.
- busy = OR of all v[i].
- Reset:
  - rst asserts all v[i]=0, so result_valid=0 and busy=0.
  - result_data=0 and result_zero=1 while reset.
  - Asserting rst mid-operation discards all in-flight transactions.
  - First accept is possible in the first cycle after rst deasserts.
- X-safety: a_data/b_data/op are don't-care when no accept occurs; they must not corrupt held stages.

Test Plan:
- LATENCY=2, WIDTH=32, result_ready=1; a=0xF0F0_F0F0, b=0xFF00_FF00, op sweep 0..7 on consecutive cycles -> 0xF000_F000, 0xFFF0_FFF0, 0x0FF0_0FF0, 0x0FFF_0FFF, 0x000F_000F, 0xF00F_F00F, 0x00F0_00F0, 0xF0FF_F0FF, in order, first result 2 cycles after first accept, then one per cycle.
- Join: a_valid=1 held, b_valid=0 for 3 cycles -> a_ready=0, no accept. Then b_valid=1 -> single accept, one result.
- Backpressure: result_ready=0 with continuous operands -> exactly LATENCY accepts, then ready low, result_data stable. Raise result_ready -> results drain in order with no loss or duplication.
- Zero flag: a=b=0x1234_5678, op=2 -> result_data=0, result_zero=1. op=0 -> result_zero=0.
- Reset mid-flight: 2 transactions in flight, pulse rst asynchronously between edges -> result_valid and busy drop immediately, no stale result appears after release.
- Random stress: WIDTH=8, LATENCY=3, random valids, readies and ops over 10k cycles -> scoreboard matches, FIFO order kept, no valid-depends-on-ready violation.
